// File: rtl/pocket_video_out.sv
// pocket_video_out
// Pixel-output stage between the ULA video controller and the Analogue Pocket
// video interface. Maps standard / ULA+ GRB332 / ULA+ mono colour to 24-bit
// RGB, derives DE, turns level syncs into single-tick HS/VS pulses (HS is
// postponed when it collides with VS), emits the end-of-line scaler-slot word
// and measures active width and height.
//
// Ports:
//   clk_sys, reset           master clock, synchronous active-high reset
//   ce_pix                   pixel enable; all state advances only on it
//   I, R, G, B               standard colour bits of the current pixel
//   ulap_ena, ulap_mono      ULA+ palette enable / greyscale mode
//   ulap_color[7:0]          ULA+ colour, GRB332
//   HSync, VSync             level syncs from the ULA
//   PHBlank, PVBlank         Pocket-window blanking
//   scaler_slot[2:0]         slot index sent on the first blank tick of a line
//   video_rgb[23:0]          {R,G,B}
//   video_de, video_hs, video_vs
//   h_active[9:0]            DE ticks of the last completed line
//   v_active[8:0]            active lines of the last completed frame
`timescale 1ns/1ps

module pocket_video_out #(
  parameter int         HS_DELAY  = 3,
  parameter logic [7:0] DIM_LEVEL = 8'hD7
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        I,
  input  logic        R,
  input  logic        G,
  input  logic        B,
  input  logic        ulap_ena,
  input  logic        ulap_mono,
  input  logic [7:0]  ulap_color,
  input  logic        HSync,
  input  logic        VSync,
  input  logic        PHBlank,
  input  logic        PVBlank,
  input  logic [2:0]  scaler_slot,
  output logic [23:0] video_rgb,
  output logic        video_de,
  output logic        video_hs,
  output logic        video_vs,
  output logic [9:0]  h_active,
  output logic [8:0]  v_active
);

  localparam logic [7:0] HS_LOAD = 8'(HS_DELAY);

  // Stage 1 registers
  logic       iS1_q, rS1_q, gS1_q, bS1_q, ulapEnaS1_q, ulapMonoS1_q;
  logic       iS1_d, rS1_d, gS1_d, bS1_d, ulapEnaS1_d, ulapMonoS1_d;
  logic [7:0] ulapColS1_q, ulapColS1_d;
  logic       hsyncS1_q, vsyncS1_q, deS1_q, validS1_q;
  logic       hsyncS1_d, vsyncS1_d, deS1_d, validS1_d;

  // Stage 2 registers
  logic [23:0] rgbS2_q, rgbS2_d;
  logic        deS2_q, hsRiseS2_q, vsRiseS2_q, hsyncPrev_q, vsyncPrev_q;
  logic        deS2_d, hsRiseS2_d, vsRiseS2_d, hsyncPrev_d, vsyncPrev_d;

  // Stage 3 / output registers and measurement state
  logic [23:0] rgb_q, rgb_d;
  logic        de_q, hs_q, vs_q, lineSeen_q;
  logic        de_d, hs_d, vs_d, lineSeen_d;
  logic [7:0]  hsCnt_q, hsCnt_d;
  logic [9:0]  pixCnt_q, pixCnt_d, hActive_q, hActive_d;
  logic [8:0]  lineCnt_q, lineCnt_d, vActive_q, vActive_d;

  // Combinational helpers
  logic [7:0]  stdLevel, ulapR, ulapG, ulapB;
  logic [23:0] mappedRgb;
  logic        hsRise, vsRise, deFall, hsPending, seenNow;
  logic [8:0]  lineCntBumped;

  // The prev registers only follow stage 1 once it holds a real sample, so a
  // sync that is already high when reset releases never looks like an edge.
  assign hsRise    = validS1_q & hsyncS1_q & ~hsyncPrev_q;
  assign vsRise    = validS1_q & vsyncS1_q & ~vsyncPrev_q;
  assign deFall    = de_q & ~deS2_q;
  assign hsPending = (hsCnt_q != 8'd0);

  // A line that ends on the same tick as its HS edge still counts.
  assign seenNow       = lineSeen_q | deFall;
  assign lineCntBumped = (hsRiseS2_q && seenNow && lineCnt_q != 9'd511)
                         ? lineCnt_q + 9'd1 : lineCnt_q;

  // Colour map from the stage-1 sample: standard palette, ULA+ GRB332 with
  // bit replication to fill 8 bits, or ULA+ greyscale.
  always_comb begin : mapColour
    stdLevel = iS1_q ? 8'hFF : DIM_LEVEL;
    ulapR    = {ulapColS1_q[4:2], ulapColS1_q[4:2], ulapColS1_q[4:3]};
    ulapG    = {ulapColS1_q[7:5], ulapColS1_q[7:5], ulapColS1_q[7:6]};
    ulapB    = {4{ulapColS1_q[1:0]}};
    if (!ulapEnaS1_q) begin
      mappedRgb = {rS1_q ? stdLevel : 8'h00,
                   gS1_q ? stdLevel : 8'h00,
                   bS1_q ? stdLevel : 8'h00};
    end else if (ulapMonoS1_q) begin
      mappedRgb = {3{ulapColS1_q}};
    end else begin
      mappedRgb = {ulapR, ulapG, ulapB};
    end
  end

  // Next-state logic for the whole pipeline; everything holds unless ce_pix.
  always_comb begin : nextState
    iS1_d        = iS1_q;
    rS1_d        = rS1_q;
    gS1_d        = gS1_q;
    bS1_d        = bS1_q;
    ulapEnaS1_d  = ulapEnaS1_q;
    ulapMonoS1_d = ulapMonoS1_q;
    ulapColS1_d  = ulapColS1_q;
    hsyncS1_d    = hsyncS1_q;
    vsyncS1_d    = vsyncS1_q;
    deS1_d       = deS1_q;
    validS1_d    = validS1_q;
    rgbS2_d      = rgbS2_q;
    deS2_d       = deS2_q;
    hsRiseS2_d   = hsRiseS2_q;
    vsRiseS2_d   = vsRiseS2_q;
    hsyncPrev_d  = hsyncPrev_q;
    vsyncPrev_d  = vsyncPrev_q;
    rgb_d        = rgb_q;
    de_d         = de_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    hsCnt_d      = hsCnt_q;
    pixCnt_d     = pixCnt_q;
    hActive_d    = hActive_q;
    lineCnt_d    = lineCnt_q;
    vActive_d    = vActive_q;
    lineSeen_d   = lineSeen_q;

    if (ce_pix) begin
      iS1_d        = I;
      rS1_d        = R;
      gS1_d        = G;
      bS1_d        = B;
      ulapEnaS1_d  = ulap_ena;
      ulapMonoS1_d = ulap_mono;
      ulapColS1_d  = ulap_color;
      hsyncS1_d    = HSync;
      vsyncS1_d    = VSync;
      deS1_d       = ~PHBlank & ~PVBlank;
      validS1_d    = 1'b1;

      rgbS2_d    = mappedRgb;
      deS2_d     = deS1_q;
      hsRiseS2_d = hsRise;
      vsRiseS2_d = vsRise;
      if (validS1_q) begin
        hsyncPrev_d = hsyncS1_q;
        vsyncPrev_d = vsyncS1_q;
      end

      // The first blank tick after active video carries the scaler slot.
      de_d = deS2_q;
      if (deS2_q) begin
        rgb_d = rgbS2_q;
      end else if (deFall) begin
        rgb_d = {21'd0, scaler_slot};
      end else begin
        rgb_d = '0;
      end

      // VS always goes out at once; an HS that would coincide with VS, or
      // that arrives while one is still pending, (re)starts the delay.
      vs_d = vsRiseS2_q;
      hs_d = 1'b0;
      if (hsRiseS2_q) begin
        if (vsRiseS2_q || hsPending) begin
          hsCnt_d = HS_LOAD;
        end else begin
          hs_d = 1'b1;
        end
      end else if (hsPending) begin
        if (hsCnt_q == 8'd1) begin
          if (vsRiseS2_q) begin
            hsCnt_d = HS_LOAD;
          end else begin
            hs_d    = 1'b1;
            hsCnt_d = 8'd0;
          end
        end else begin
          hsCnt_d = hsCnt_q - 8'd1;
        end
      end

      if (deS2_q) begin
        if (pixCnt_q != 10'd1023) begin
          pixCnt_d = pixCnt_q + 10'd1;
        end
      end else if (deFall) begin
        hActive_d = pixCnt_q;
        pixCnt_d  = 10'd0;
      end

      lineSeen_d = hsRiseS2_q ? 1'b0 : seenNow;
      if (vsRiseS2_q) begin
        vActive_d = lineCntBumped;
        lineCnt_d = 9'd0;
      end else begin
        lineCnt_d = lineCntBumped;
      end
    end
  end

  // State register; sync prev registers reset high so no spurious edge.
  always_ff @(posedge clk_sys) begin : stateReg
    if (reset) begin
      iS1_q        <= 1'b0;
      rS1_q        <= 1'b0;
      gS1_q        <= 1'b0;
      bS1_q        <= 1'b0;
      ulapEnaS1_q  <= 1'b0;
      ulapMonoS1_q <= 1'b0;
      ulapColS1_q  <= 8'd0;
      hsyncS1_q    <= 1'b0;
      vsyncS1_q    <= 1'b0;
      deS1_q       <= 1'b0;
      validS1_q    <= 1'b0;
      rgbS2_q      <= 24'd0;
      deS2_q       <= 1'b0;
      hsRiseS2_q   <= 1'b0;
      vsRiseS2_q   <= 1'b0;
      hsyncPrev_q  <= 1'b1;
      vsyncPrev_q  <= 1'b1;
      rgb_q        <= 24'd0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      hsCnt_q      <= 8'd0;
      pixCnt_q     <= 10'd0;
      hActive_q    <= 10'd0;
      lineCnt_q    <= 9'd0;
      vActive_q    <= 9'd0;
      lineSeen_q   <= 1'b0;
    end else begin
      iS1_q        <= iS1_d;
      rS1_q        <= rS1_d;
      gS1_q        <= gS1_d;
      bS1_q        <= bS1_d;
      ulapEnaS1_q  <= ulapEnaS1_d;
      ulapMonoS1_q <= ulapMonoS1_d;
      ulapColS1_q  <= ulapColS1_d;
      hsyncS1_q    <= hsyncS1_d;
      vsyncS1_q    <= vsyncS1_d;
      deS1_q       <= deS1_d;
      validS1_q    <= validS1_d;
      rgbS2_q      <= rgbS2_d;
      deS2_q       <= deS2_d;
      hsRiseS2_q   <= hsRiseS2_d;
      vsRiseS2_q   <= vsRiseS2_d;
      hsyncPrev_q  <= hsyncPrev_d;
      vsyncPrev_q  <= vsyncPrev_d;
      rgb_q        <= rgb_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      hsCnt_q      <= hsCnt_d;
      pixCnt_q     <= pixCnt_d;
      hActive_q    <= hActive_d;
      lineCnt_q    <= lineCnt_d;
      vActive_q    <= vActive_d;
      lineSeen_q   <= lineSeen_d;
    end
  end

  assign video_rgb = rgb_q;
  assign video_de  = de_q;
  assign video_hs  = hs_q;
  assign video_vs  = vs_q;
  assign h_active  = hActive_q;
  assign v_active  = vActive_q;

endmodule

// File: tb/tb_pocket_video_out.sv
// Testbench for pocket_video_out: table of colour vectors, hand-written
// sequences for reset, end-of-line word, VS/HS collision, frame height and
// mid-line reset, then randomized ticks against a history-based model.
`timescale 1ns/1ps

module tb_pocket_video_out;

  localparam int         HS_DELAY  = 3;
  localparam logic [7:0] DIM_LEVEL = 8'hD7;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic        I = 1'b0, R = 1'b0, G = 1'b0, B = 1'b0;
  logic        ulap_ena = 1'b0, ulap_mono = 1'b0;
  logic [7:0]  ulap_color = 8'd0;
  logic        HSync = 1'b0, VSync = 1'b0, PHBlank = 1'b1, PVBlank = 1'b1;
  logic [2:0]  scaler_slot = 3'd0;
  logic [23:0] video_rgb;
  logic        video_de, video_hs, video_vs;
  logic [9:0]  h_active;
  logic [8:0]  v_active;

  int nCompared = 0;
  int nMismatched = 0;

  pocket_video_out #(.HS_DELAY(HS_DELAY), .DIM_LEVEL(DIM_LEVEL)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .I(I), .R(R), .G(G), .B(B),
    .ulap_ena(ulap_ena), .ulap_mono(ulap_mono), .ulap_color(ulap_color),
    .HSync(HSync), .VSync(VSync), .PHBlank(PHBlank), .PVBlank(PVBlank),
    .scaler_slot(scaler_slot),
    .video_rgb(video_rgb), .video_de(video_de),
    .video_hs(video_hs), .video_vs(video_vs),
    .h_active(h_active), .v_active(v_active)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic i, r, g, b, ena, mono;
    logic [7:0] col;
    logic hs, vs, phb, pvb;
  } inRec_t;

  typedef struct {
    logic i, r, g, b, ena, mono;
    logic [7:0] col;
    logic [23:0] expRgb;
  } colourVec_t;

  inRec_t     cur;
  inRec_t     hist[4096];
  colourVec_t tbl[11];

  // Reference model state
  logic [2:0]  rndSlot;
  logic        eDe, eHs, eVs;
  logic [23:0] eRgb;
  int mDePrev, mRun, mHAct, mSeen, mLines, mVAct, mHsDue;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic drivePins(input inRec_t x);
    I = x.i; R = x.r; G = x.g; B = x.b;
    ulap_ena = x.ena; ulap_mono = x.mono; ulap_color = x.col;
    HSync = x.hs; VSync = x.vs; PHBlank = x.phb; PVBlank = x.pvb;
  endtask

  task automatic applyStimulus(input inRec_t x);
    drivePins(x);
    ce_pix = 1'b1;
    @(posedge clk_sys);
    #1;
    ce_pix = 1'b0;
  endtask

  task automatic idleClock();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic modelReset();
    mDePrev = 0; mRun = 0; mHAct = 0; mSeen = 0;
    mLines = 0; mVAct = 0; mHsDue = -1;
  endtask

  task automatic doReset();
    ce_pix = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  // Colour rules written as arithmetic: replication {r,r,r[2:1]} equals
  // r*32 + r*4 + r/2, and {b,b,b,b} equals b*85.
  function automatic logic [23:0] refColour(input inRec_t x);
    int lv, rr, gg, bb, r3, g3, b2;
    if (!x.ena) begin
      lv = x.i ? 255 : int'(DIM_LEVEL);
      rr = x.r ? lv : 0;
      gg = x.g ? lv : 0;
      bb = x.b ? lv : 0;
    end else if (x.mono) begin
      rr = int'(x.col); gg = rr; bb = rr;
    end else begin
      r3 = int'(x.col[4:2]);
      g3 = int'(x.col[7:5]);
      b2 = int'(x.col[1:0]);
      rr = r3 * 32 + r3 * 4 + r3 / 2;
      gg = g3 * 32 + g3 * 4 + g3 / 2;
      bb = b2 * 85;
    end
    return {8'(rr), 8'(gg), 8'(bb)};
  endfunction

  // Expected outputs after tick k, from the input history: outputs reflect
  // the input two ticks earlier; edges compare against the tick before that
  // (treated as high before the first tick after reset).
  task automatic modelStep(input int k);
    logic de, fall, hsr, vsr, prevHs, prevVs;
    de     = (k >= 2) ? (~hist[k-2].phb & ~hist[k-2].pvb) : 1'b0;
    fall   = (mDePrev != 0) && !de;
    prevHs = (k >= 3) ? hist[k-3].hs : 1'b1;
    prevVs = (k >= 3) ? hist[k-3].vs : 1'b1;
    hsr    = (k >= 2) && hist[k-2].hs && !prevHs;
    vsr    = (k >= 2) && hist[k-2].vs && !prevVs;
    eDe    = de;
    eRgb   = de ? refColour(hist[k-2]) : (fall ? {21'd0, rndSlot} : 24'd0);
    eVs    = vsr;
    eHs    = 1'b0;
    if (hsr) begin
      if (vsr || mHsDue >= 0) mHsDue = k + HS_DELAY;
      else eHs = 1'b1;
    end else if (mHsDue == k) begin
      if (vsr) mHsDue = k + HS_DELAY;
      else begin eHs = 1'b1; mHsDue = -1; end
    end
    if (de) begin
      if (mRun < 1023) mRun++;
    end else if (fall) begin
      mHAct = mRun; mRun = 0; mSeen = 1;
    end
    if (hsr) begin
      if (mSeen != 0 && mLines < 511) mLines++;
      mSeen = 0;
    end
    if (vsr) begin
      mVAct = mLines; mLines = 0;
    end
    mDePrev = de ? 1 : 0;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_de"}, 32'(video_de), 32'(eDe));
    checkOutput({tag, "_rgb"}, 32'(video_rgb), 32'(eRgb));
    checkOutput({tag, "_hs"}, 32'(video_hs), 32'(eHs));
    checkOutput({tag, "_vs"}, 32'(video_vs), 32'(eVs));
    checkOutput({tag, "_hact"}, 32'(h_active), 32'(mHAct));
    checkOutput({tag, "_vact"}, 32'(v_active), 32'(mVAct));
    checkOutput({tag, "_hsvs_excl"}, 32'(video_hs & video_vs), 32'd0);
  endtask

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic seen;

    // {i,r,g,b,ena,mono,col,expected}
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 24'hD700D7};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 24'hFFFFFF};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 24'h000000};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 24'hD7D700};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 24'h0000FF};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b101_011_10, 24'h6DB6AA};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 24'h5A5A5A};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 24'hFFFFFF};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b000_111_01, 24'hFF0055};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 24'h000000};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 24'h000000};

    // Reset with both syncs held high: no pulses, everything zero.
    cur = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    drivePins(cur);
    doReset();
    checkOutput("rst_de", 32'(video_de), 32'd0);
    checkOutput("rst_rgb", 32'(video_rgb), 32'd0);
    checkOutput("rst_hs", 32'(video_hs), 32'd0);
    checkOutput("rst_vs", 32'(video_vs), 32'd0);
    checkOutput("rst_hact", 32'(h_active), 32'd0);
    checkOutput("rst_vact", 32'(v_active), 32'd0);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(cur);
      checkOutput("rel_hs", 32'(video_hs), 32'd0);
      checkOutput("rel_vs", 32'(video_vs), 32'd0);
      checkOutput("rel_rgb", 32'(video_rgb), 32'd0);
    end

    // Colour table: each vector appears two ticks after it is applied.
    cur.hs = 1'b0; cur.vs = 1'b0; cur.phb = 1'b0; cur.pvb = 1'b0;
    for (int n = 0; n < 13; n++) begin
      if (n < 11) begin
        cur.i = tbl[n].i; cur.r = tbl[n].r; cur.g = tbl[n].g; cur.b = tbl[n].b;
        cur.ena = tbl[n].ena; cur.mono = tbl[n].mono; cur.col = tbl[n].col;
      end
      applyStimulus(cur);
      if (n < 2) begin
        checkOutput("tbl_de_latency", 32'(video_de), 32'd0);
        checkOutput("tbl_rgb_latency", 32'(video_rgb), 32'd0);
      end else begin
        checkOutput("tbl_de", 32'(video_de), 32'd1);
        checkOutput($sformatf("tbl_rgb[%0d]", n - 2), 32'(video_rgb), 32'(tbl[n-2].expRgb));
      end
    end

    // 512-pixel line then blank: scaler slot word for one tick, then zero.
    cur.phb = 1'b1;
    repeat (4) applyStimulus(cur);
    scaler_slot = 3'd3;
    cur = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (512) applyStimulus(cur);
    cur.phb = 1'b1;
    for (int j = 0; j < 4; j++) begin
      applyStimulus(cur);
      if (j == 1) begin
        checkOutput("eol_last_pix", 32'(video_rgb), 32'hFF0000);
        checkOutput("eol_last_de", 32'(video_de), 32'd1);
      end else if (j == 2) begin
        checkOutput("eol_word", 32'(video_rgb), 32'h000003);
        checkOutput("eol_de", 32'(video_de), 32'd0);
        checkOutput("eol_hact", 32'(h_active), 32'd512);
      end else if (j == 3) begin
        checkOutput("eol_after", 32'(video_rgb), 32'd0);
      end
    end

    // HSync and VSync rise together: VS at +2, HS at +2+HS_DELAY.
    repeat (2) applyStimulus(cur);
    cur.hs = 1'b1; cur.vs = 1'b1;
    for (int d = 0; d < 10; d++) begin
      applyStimulus(cur);
      checkOutput($sformatf("coll_vs[+%0d]", d), 32'(video_vs), 32'(d == 2));
      checkOutput($sformatf("coll_hs[+%0d]", d), 32'(video_hs), 32'(d == 2 + HS_DELAY));
    end

    // Frame of 240 short lines between two VSync rises.
    cur = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    drivePins(cur);
    doReset();
    repeat (3) applyStimulus(cur);
    cur.vs = 1'b1; applyStimulus(cur);
    cur.vs = 1'b0; applyStimulus(cur);
    for (int ln = 0; ln < 240; ln++) begin
      cur.phb = 1'b0; repeat (4) applyStimulus(cur);
      cur.phb = 1'b1; repeat (2) applyStimulus(cur);
      cur.hs = 1'b1; applyStimulus(cur);
      cur.hs = 1'b0; applyStimulus(cur);
    end
    repeat (2) applyStimulus(cur);
    cur.vs = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 8 && !seen; w++) begin
      applyStimulus(cur);
      seen = video_vs;
    end
    checkOutput("frame_vs_seen", 32'(seen), 32'd1);
    applyStimulus(cur);
    checkOutput("frame_vact", 32'(v_active), 32'd240);
    checkOutput("frame_hact", 32'(h_active), 32'd4);

    // Reset in the middle of a line: DE drops on the next clock, no EOL word.
    cur.phb = 1'b0; cur.vs = 1'b0;
    repeat (5) applyStimulus(cur);
    checkOutput("midrst_pre_de", 32'(video_de), 32'd1);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    checkOutput("midrst_de", 32'(video_de), 32'd0);
    checkOutput("midrst_rgb", 32'(video_rgb), 32'd0);
    checkOutput("midrst_hact", 32'(h_active), 32'd0);
    checkOutput("midrst_vact", 32'(v_active), 32'd0);
    reset = 1'b0;
    scaler_slot = 3'd5;
    cur.phb = 1'b1;
    for (int n = 0; n < 3; n++) begin
      applyStimulus(cur);
      checkOutput("midrst_no_eol", 32'(video_rgb), 32'd0);
      checkOutput("midrst_de_low", 32'(video_de), 32'd0);
    end

    // Randomized run against the history model, with ce_pix gaps.
    rndSlot = 3'($urandom_range(0, 7));
    scaler_slot = rndSlot;
    cur.hs = 1'($urandom_range(0, 1));
    cur.vs = 1'($urandom_range(0, 1));
    cur.phb = 1'b1; cur.pvb = 1'b0;
    drivePins(cur);
    doReset();
    for (int k = 0; k < 3000; k++) begin
      cur.i = 1'($urandom_range(0, 1));
      cur.r = 1'($urandom_range(0, 1));
      cur.g = 1'($urandom_range(0, 1));
      cur.b = 1'($urandom_range(0, 1));
      cur.ena = 1'($urandom_range(0, 1));
      cur.mono = ($urandom_range(0, 3) == 0);
      cur.col = 8'($urandom);
      if ($urandom_range(0, 5) == 0) cur.hs = ~cur.hs;
      if ($urandom_range(0, 39) == 0) begin
        cur.vs = ~cur.vs;
        if (cur.vs && $urandom_range(0, 1) == 1) cur.hs = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) cur.phb = ~cur.phb;
      if ($urandom_range(0, 59) == 0) cur.pvb = ~cur.pvb;
      hist[k] = cur;
      applyStimulus(cur);
      modelStep(k);
      checkModel("rnd");
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        idleClock();
        checkModel("rnd_hold");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
